sram_port_master: RTL and testbench

// - Initiator for one RW port of the dual-port SRAM (csb/web/wmask/addr/din/dout, active-low selects).
// - Converts core-side byte-addressed load/store requests into SRAM word accesses.
// - Generates write masks and lane-replicated write data; aligns and extends read data.
// - One instance per SRAM port (e.g. instruction fetch on port 1, data on port 0).

---
 rtl/sram_port_master_if.sv | 13 +
 rtl/sram_port_master.sv | 112 +++++++++++
 tb/tb_sram_port_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_master_if.sv
// sram_port_master_if: core load/store handshake plus SRAM RW-port signals.
// master = sram_port_master view; slave = requester and SRAM macro view.
interface sram_port_master_if #(parameter int ADDR_WIDTH = 9);
  logic                  req, we, uns, ready, rvalid, err, csb, web;
  logic [1:0]            size;
  logic [31:0]           addr, wdata, rdata, din, dout;
  logic [3:0]            wmask;
  logic [ADDR_WIDTH-1:0] saddr;
  modport master (input req, we, size, uns, addr, wdata, dout,
                  output ready, rvalid, rdata, err, csb, web, wmask, saddr, din);
  modport slave (output req, we, size, uns, addr, wdata, dout,
                 input ready, rvalid, rdata, err, csb, web, wmask, saddr, din);
endinterface

// File: rtl/sram_port_master.sv
// sram_port_master: byte-addressed load/store initiator for one SRAM RW port.
// Optional SRAM_MASTER_ALIGN_CHECK_EN flags misaligned/reserved-size requests with err.
module sram_port_master #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
) (
  input logic               clk_i,
  input logic               reset_i,
  sram_port_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  state_e                state_q, state_d;
  logic                  we_q, we_d, uns_q, uns_d, flag_q, flag_d;
  logic [1:0]            size_q, size_d, off_q, off_d;
  logic                  csb_q, csb_d, web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d, lane_mask;
  logic [ADDR_WIDTH-1:0] saddr_q, saddr_d;
  logic [31:0]           din_q, din_d, lane_data, shifted, load_val;
  logic [1:0]            eff_size, eff_off;
  logic                  flag, accept, unused_addr;
  assign unused_addr = ^bus.addr[31:ADDR_WIDTH+2];
  assign accept = state_q == IDLE && bus.req;
`ifdef SRAM_MASTER_ALIGN_CHECK_EN
  assign flag = bus.size == 2'b11 || (bus.size == 2'b01 && bus.addr[0]) ||
                (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
  assign eff_size = bus.size;
  assign eff_off = bus.addr[1:0];
`else
  // Without the checker, misalignment is silently resolved by clearing low bits.
  assign flag = 1'b0;
  assign eff_size = bus.size == 2'b11 ? 2'b10 : bus.size;
  assign eff_off = eff_size == 2'b10 ? 2'b00 :
                   eff_size == 2'b01 ? {bus.addr[1], 1'b0} : bus.addr[1:0];
`endif
  assign lane_mask = eff_size == 2'b00 ? 4'b0001 << eff_off :
                     eff_size == 2'b01 ? (eff_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane_data = eff_size == 2'b00 ? {4{bus.wdata[7:0]}} :
                     eff_size == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      flag_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      saddr_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      flag_q  <= flag_d;
      size_q  <= size_d;
      off_q   <= off_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      saddr_q <= saddr_d;
      din_q   <= din_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE   ? (bus.req ? (flag ? RESP : ACCESS) : IDLE) :
              state_q == ACCESS ? RESP : IDLE;
  end
  always_comb begin
    we_d    = we_q;
    uns_d   = uns_q;
    flag_d  = flag_q;
    size_d  = size_q;
    off_d   = off_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    saddr_d = saddr_q;
    din_d   = din_q;
    if (accept) begin
      we_d    = bus.we;
      uns_d   = bus.uns;
      flag_d  = flag;
      size_d  = eff_size;
      off_d   = eff_off;
      csb_d   = flag;
      web_d   = flag | ~bus.we;
      wmask_d = (flag | ~bus.we) ? '0 : lane_mask;
      saddr_d = bus.addr[ADDR_WIDTH+1:2];
      din_d   = lane_data;
    end else if (state_q == ACCESS) begin
      csb_d   = 1'b1;
      web_d   = 1'b1;
      wmask_d = '0;
    end
  end
  always_comb begin
    shifted    = bus.dout >> {off_q, 3'b000};
    load_val   = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                 size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
    bus.ready  = state_q == IDLE;
    bus.rvalid = state_q == RESP;
    bus.rdata  = (state_q == RESP && !we_q && !flag_q) ? load_val : 32'h0;
    bus.err    = state_q == RESP && flag_q;
    bus.csb    = csb_q;
    bus.web    = web_q;
    bus.wmask  = wmask_q;
    bus.saddr  = saddr_q;
    bus.din    = din_q;
  end
endmodule

// File: tb/tb_sram_port_master.sv
// tb_sram_port_master: scoreboard bench with a behavioural SRAM behind the port.
module tb_sram_port_master;
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 0, rst_n = 0;
  int checks = 0, fails = 0, rv_count = 0, cyc = 0;
  exp_t exp_q[$];
  int acc_cyc[$];
  logic [31:0] mem [512];
  sram_port_master_if #(.ADDR_WIDTH(9)) bus ();
  sram_port_master #(.ADDR_WIDTH(9), .NUM_WMASKS(4)) dut (.clk_i(clk), .reset_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!bus.csb) begin
      if (!bus.web) begin
        for (int i = 0; i < 4; i++)
          if (bus.wmask[i]) mem[bus.saddr][8*i +: 8] <= bus.din[8*i +: 8];
      end else bus.dout <= mem[bus.saddr];
    end
  end
  always @(posedge clk) begin
    cyc++;
    if (bus.req && bus.ready) acc_cyc.push_back(cyc);
  end
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rvalid) begin
      rv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid: rdata=%h err=%b, required no response", bus.rdata, bus.err);
      end else begin
        e = exp_q.pop_front();
        if (bus.rdata !== e.rdata || bus.err !== e.err) begin
          fails++;
          $display("FAIL response: rdata=%h err=%b, required rdata=%h err=%b", bus.rdata, bus.err, e.rdata, e.err);
        end
      end
    end
  end
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee, input logic push);
    int n = 0;
    @(negedge clk);
    bus.req = 1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = d;
    while (!bus.ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.ready) begin fails++; $display("FAIL accept_timeout: ready=%b, required 1", bus.ready); end
    if (push) exp_q.push_back('{er, ee});
    @(posedge clk); #1;
    bus.req = 0;
  endtask
  task automatic wait_resp();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL resp_timeout: %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ready, bus.rvalid, bus.err, bus.rdata, bus.csb, bus.web, bus.wmask, bus.saddr, bus.din} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset: ready=%b rvalid=%b err=%b rdata=%h csb=%b web=%b wmask=%h saddr=%h din=%h, required 1 0 0 0 1 1 0 0 0",
               bus.ready, bus.rvalid, bus.err, bus.rdata, bus.csb, bus.web, bus.wmask, bus.saddr, bus.din);
    end
    rst_n = 1;
  endtask
  task automatic test_word();
    do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    checks++;
    if ({bus.csb, bus.web, bus.wmask, bus.saddr, bus.din} !== {1'b0, 1'b0, 4'hF, 9'd4, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL port_store_word: csb=%b web=%b wmask=%h saddr=%h din=%h, required 0 0 f 004 deadbeef",
               bus.csb, bus.web, bus.wmask, bus.saddr, bus.din);
    end
    wait_resp();
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    checks++;
    if ({bus.csb, bus.web, bus.wmask, bus.saddr} !== {1'b0, 1'b1, 4'h0, 9'd4}) begin
      fails++;
      $display("FAIL port_load_word: csb=%b web=%b wmask=%h saddr=%h, required 0 1 0 004",
               bus.csb, bus.web, bus.wmask, bus.saddr);
    end
    wait_resp();
  endtask
  task automatic test_byte_half();
    do_req(1, 2'b00, 0, 32'h13, 32'h000000A5, 32'h0, 0, 1);
    checks++;
    if ({bus.wmask, bus.din} !== {4'b1000, 32'hA5A5A5A5}) begin
      fails++;
      $display("FAIL port_store_byte: wmask=%b din=%h, required 1000 a5a5a5a5", bus.wmask, bus.din);
    end
    wait_resp();
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 1);
    do_req(1, 2'b10, 0, 32'h20, 32'h80011234, 32'h0, 0, 1);
    do_req(1, 2'b00, 0, 32'h20, 32'h00000080, 32'h0, 0, 1);
    do_req(0, 2'b00, 0, 32'h20, 32'h0, 32'hFFFFFF80, 0, 1);
    do_req(0, 2'b00, 1, 32'h20, 32'h0, 32'h00000080, 0, 1);
    do_req(0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF8001, 0, 1);
    do_req(0, 2'b01, 1, 32'h22, 32'h0, 32'h00008001, 0, 1);
    do_req(1, 2'b01, 0, 32'h26, 32'h0000BEEF, 32'h0, 0, 1);
    checks++;
    if ({bus.wmask, bus.saddr, bus.din} !== {4'b1100, 9'd9, 32'hBEEFBEEF}) begin
      fails++;
      $display("FAIL port_store_half: wmask=%b saddr=%h din=%h, required 1100 009 beefbeef", bus.wmask, bus.saddr, bus.din);
    end
    do_req(0, 2'b10, 0, 32'h24, 32'h0, 32'hBEEF0000, 0, 1);
    wait_resp();
  endtask
  task automatic test_misaligned();
`ifdef SRAM_MASTER_ALIGN_CHECK_EN
    do_req(0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 1, 1);
    checks++;
    if ({bus.csb, bus.rvalid, bus.err} !== 3'b111) begin
      fails++;
      $display("FAIL misaligned_flag: csb=%b rvalid=%b err=%b, required 1 1 1", bus.csb, bus.rvalid, bus.err);
    end
`else
    do_req(0, 2'b10, 0, 32'h22, 32'h0, 32'h80011280, 0, 1);
    checks++;
    if ({bus.csb, bus.saddr} !== {1'b0, 9'd8}) begin
      fails++;
      $display("FAIL misaligned_forced: csb=%b saddr=%h, required 0 008", bus.csb, bus.saddr);
    end
`endif
    wait_resp();
  endtask
  task automatic test_wrap();
    do_req(1, 2'b10, 0, 32'h810, 32'h12345678, 32'h0, 0, 1);
    checks++;
    if (bus.saddr !== 9'd4) begin
      fails++;
      $display("FAIL addr_wrap: saddr=%h, required 004", bus.saddr);
    end
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'h12345678, 0, 1);
    wait_resp();
  endtask
  task automatic test_abort();
    int r0;
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0);
    r0 = rv_count;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.csb, bus.ready, bus.rvalid} !== 3'b110) begin
      fails++;
      $display("FAIL abort_outputs: csb=%b ready=%b rvalid=%b, required 1 1 0", bus.csb, bus.ready, bus.rvalid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (rv_count != r0) begin
      fails++;
      $display("FAIL abort_no_resp: %0d pulses, required 0", rv_count - r0);
    end
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'h12345678, 0, 1);
    wait_resp();
  endtask
  task automatic test_back_to_back();
    int n = 0, r0 = rv_count;
    acc_cyc.delete();
    @(negedge clk);
    bus.req = 1; bus.we = 0; bus.size = 2'b10; bus.uns = 0; bus.addr = 32'h10; bus.wdata = 0;
    repeat (3) exp_q.push_back('{32'h12345678, 1'b0});
    while (acc_cyc.size() < 3 && n < 30) begin @(negedge clk); n++; end
    bus.req = 0;
    wait_resp();
    repeat (3) @(negedge clk);
    checks++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      fails++;
      $display("FAIL b2b_accepts: %0d accepts, required 3 spaced by 3", acc_cyc.size());
    end
    checks++;
    if (rv_count - r0 != 3) begin
      fails++;
      $display("FAIL b2b_pulses: %0d, required 3", rv_count - r0);
    end
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    bus.req = 0; bus.we = 0; bus.size = 0; bus.uns = 0; bus.addr = 0; bus.wdata = 0; bus.dout = 0;
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_wrap();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
